// File: rtl/key_evt_pkg.sv
// Shared state encoding and default 50 MHz timing for the key event decoder.
package key_evt_pkg;

  typedef enum logic [2:0] {ARM, IDLE, PRESS1, GAP, HELD, WAITREL} kev_state_t;

  localparam int LONG_CYC_DEF = 50_000_000;  // 1 s
  localparam int DCLK_CYC_DEF = 12_500_000;  // 250 ms
  localparam int REP_CYC_DEF  = 10_000_000;  // 200 ms
  localparam int CNT_W_DEF    = 26;

endpackage

// File: rtl/kev_timer.sv
// Saturating up-counter with synchronous clear/enable and terminal-count flag.
module kev_timer #(
  parameter int CNT_W = 26
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_term,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == i_term);

endmodule

// File: rtl/key_event_decoder.sv
// Classifies debounced key presses into short/double/long events plus a hold level.
// Optional auto-repeat while held is enabled by defining KEY_REPEAT_EN.
module key_event_decoder
  import key_evt_pkg::*;
#(
  parameter int LONG_CYC = LONG_CYC_DEF,
  parameter int DCLK_CYC = DCLK_CYC_DEF,
  parameter int REP_CYC  = REP_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic KP,
  output logic SHORT_EV,
  output logic DOUBLE_EV,
  output logic LONG_EV,
  output logic HOLD,
  output logic REPEAT_EV
);

  localparam int MAX_CYC = (LONG_CYC > DCLK_CYC) ?
                           ((LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC) :
                           ((DCLK_CYC > REP_CYC) ? DCLK_CYC : REP_CYC);
  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DCLK_TERM = CNT_W'(DCLK_CYC - 1);

  if ($clog2(MAX_CYC) > CNT_W) begin : g_cnt_w_check
    $error("CNT_W too narrow for the configured cycle counts");
  end

  kev_state_t       r_state;
  logic             r_short, r_double, r_long, r_hold;
  logic             w_tc, w_chg, w_en;
  logic [CNT_W-1:0] w_term;

  // Timer restarts whenever the FSM is about to leave its current state.
  always_comb begin
    w_chg = 1'b0;
    case (r_state)
      ARM:     w_chg = KP;
      IDLE:    w_chg = !KP;
      PRESS1:  w_chg = KP || w_tc;
      GAP:     w_chg = !KP || w_tc;
      HELD:    w_chg = KP;
      WAITREL: w_chg = KP;
      default: w_chg = 1'b1;
    endcase
  end

  assign w_en   = (r_state == PRESS1) || (r_state == GAP);
  assign w_term = (r_state == PRESS1) ? LONG_TERM : DCLK_TERM;

  kev_timer #(.CNT_W(CNT_W)) u_main_tmr (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_clr  (w_chg),
    .i_en   (w_en),
    .i_term (w_term),
    .o_tc   (w_tc)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ARM;
      r_short  <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
      r_hold   <= 1'b0;
    end else begin
      r_short  <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
      case (r_state)
        ARM:  if (KP) r_state <= IDLE;
        IDLE: if (!KP) r_state <= PRESS1;
        PRESS1: begin
          if (KP) begin
            r_state <= GAP;
          end else if (w_tc) begin
            r_state <= HELD;
            r_long  <= 1'b1;
            r_hold  <= 1'b1;
          end
        end
        // A second press on the expiry cycle still counts as a double click.
        GAP: begin
          if (!KP) begin
            r_state  <= WAITREL;
            r_double <= 1'b1;
          end else if (w_tc) begin
            r_state <= IDLE;
            r_short <= 1'b1;
          end
        end
        HELD: begin
          if (KP) begin
            r_state <= IDLE;
            r_hold  <= 1'b0;
          end
        end
        WAITREL: if (KP) r_state <= IDLE;
        default: r_state <= ARM;
      endcase
    end
  end

  assign SHORT_EV  = r_short;
  assign DOUBLE_EV = r_double;
  assign LONG_EV   = r_long;
  assign HOLD      = r_hold;

`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_TERM = CNT_W'(REP_CYC - 1);
  logic w_rep_tc, w_rep_clr, w_in_held, r_repeat;

  assign w_in_held = (r_state == HELD);
  assign w_rep_clr = !w_in_held || w_rep_tc;

  kev_timer #(.CNT_W(CNT_W)) u_rep_tmr (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_clr  (w_rep_clr),
    .i_en   (w_in_held),
    .i_term (REP_TERM),
    .o_tc   (w_rep_tc)
  );

  always_ff @(posedge CLK) begin
    if (RST) r_repeat <= 1'b0;
    else     r_repeat <= w_in_held && w_rep_tc;
  end

  assign REPEAT_EV = r_repeat;
`else
  assign REPEAT_EV = 1'b0;
`endif

endmodule
